// File: rtl/ssd_pkg.sv
// Shared types and constants for the 7-segment mux driver:
// hex-to-segment table, digit-slot enum and the update record.
package ssd_pkg;

  typedef enum logic {
    RIGHT = 1'b0,
    LEFT  = 1'b1
  } digit_e;

  typedef struct packed {
    logic [7:0] data;   // [7:4] left digit, [3:0] right digit
    logic [1:0] blank;  // [1] left, [0] right
    logic       blink;
  } upd_t;

  // Segment patterns shown as g..a (bit 6 = g, bit 0 = a), active-high.
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Power-up display state: both digits dark.
  localparam upd_t UPD_RST = '{data: 8'h00, blank: 2'b11, blink: 1'b0};

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return SEG_TBL[nib];
  endfunction

endpackage

// File: rtl/ssd_mux_driver_if.sv
// Valid/ready update port between the register file (master) and the
// display driver (slave).
interface ssd_mux_driver_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_data;
  logic [1:0] upd_blank;
  logic       upd_blink;

  modport master (output upd_valid, upd_data, upd_blank, upd_blink,
                  input  upd_ready);
  modport slave  (input  upd_valid, upd_data, upd_blank, upd_blink,
                  output upd_ready);
endinterface

// File: rtl/ssd_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last count.
module ssd_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic ACLK,
  input  logic ARESET,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap the counter on the final count of the slot.
  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Prescaler register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd_mux_driver.sv
// Two-digit multiplexed 7-segment driver. Updates are held in a one-entry
// pending register and committed only at frame boundaries so a digit pair
// is never shown half-updated. Optional blink support is compiled in with
// the SSD_BLINK_EN macro.
module ssd_mux_driver
  import ssd_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic             ACLK,
  input  logic             ARESET,
  ssd_mux_driver_if.slave  upd,
  output logic [6:0]       seg,
  output logic             digit_sel,
  output logic             frame_tick
);

  logic       slot_tick;
  logic       frame;
  logic       hs;
  logic       blink_off;
  logic       nib_blank;
  logic [3:0] nib;

  digit_e     state_q, state_d;
  upd_t       pend_q, pend_d;
  upd_t       act_q, act_d;
  logic       full_q, full_d;
  logic [6:0] seg_q, seg_d;

  ssd_tick_gen #(.DIV(DIV)) u_tick (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .tick   (slot_tick)
  );

  // Digit FSM: alternate slots on every slot tick.
  always_comb begin
    state_d = state_q;
    if (slot_tick) state_d = (state_q == RIGHT) ? LEFT : RIGHT;
  end

  assign frame = slot_tick && (state_q == LEFT);

  // Pending/active update path; commit only at a frame boundary.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    full_d = full_q;
    hs     = upd.upd_valid && !full_q;
    if (frame && full_q) begin
      act_d  = pend_q;
      full_d = 1'b0;
    end
    if (hs) begin
      pend_d = '{data: upd.upd_data, blank: upd.upd_blank, blink: upd.upd_blink};
      full_d = 1'b1;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink divider counts slots and flips the phase on wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (slot_tick) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    blink_off = act_d.blink && phase_d;
  end

  // Blink counter and phase registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  // The blink bit is still captured but never gates the display.
  logic unused_blink;
  assign unused_blink = act_q.blink & BLINK_DIV[0];
  assign blink_off    = 1'b0;
`endif

  // Segment pattern for the slot that starts on the next edge; uses the
  // post-commit value so a new frame starts with the new digit pair.
  always_comb begin
    nib       = (state_d == LEFT) ? act_d.data[7:4] : act_d.data[3:0];
    nib_blank = (state_d == LEFT) ? act_d.blank[1]  : act_d.blank[0];
    seg_d     = (nib_blank || blink_off) ? 7'h00 : hex2seg(nib);
  end

  // State, update and output registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= RIGHT;
      pend_q  <= UPD_RST;
      act_q   <= UPD_RST;
      full_q  <= 1'b0;
      seg_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      full_q  <= full_d;
      seg_q   <= seg_d;
    end
  end

  assign seg           = seg_q;
  assign digit_sel     = (state_q == LEFT);
  assign frame_tick    = frame;
  assign upd.upd_ready = !full_q;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Bench for ssd_mux_driver: table vectors, corner-case sequences and
// randomized traffic against a cycle-count based reference model.
module tb_ssd_mux_driver;

  localparam int D  = 4;
  localparam int BD = 2;

  logic       ACLK   = 1'b0;
  logic       ARESET = 1'b0;
  logic [6:0] seg;
  logic       digit_sel;
  logic       frame_tick;

  always #5 ACLK = ~ACLK;

  ssd_mux_driver_if u_if ();

  ssd_mux_driver #(.DIV(D), .BLINK_DIV(BD)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .upd        (u_if),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;  // rising edges since reset release

  typedef struct {
    logic [7:0] data;
    logic [1:0] blank;
    logic       blink;
    int         app;  // edge count at which the value becomes visible
  } rec_t;
  rec_t recs[$];

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [7:0] data;
    logic [1:0] blank;
    logic [6:0] exp_l;
    logic [6:0] exp_r;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (edge %0d)", nm, act, exp, e);
    end
  endtask

  function automatic rec_t active_at(input int ee);
    rec_t r;
    r.data = 8'h00; r.blank = 2'b11; r.blink = 1'b0; r.app = 0;
    foreach (recs[i]) if (recs[i].app <= ee) r = recs[i];
    return r;
  endfunction

  function automatic bit ready_at(input int ee);
    if (recs.size() == 0) return 1'b1;
    return ee >= recs[recs.size()-1].app;
  endfunction

  function automatic logic [6:0] exp_seg(input int ee);
    rec_t r;
    int   s;
    bit   left, dark;
    r    = active_at(ee);
    s    = ee / D;
    left = (s % 2) == 1;
    dark = left ? r.blank[1] : r.blank[0];
`ifdef SSD_BLINK_EN
    if (r.blink && ((s / BD) % 2 == 1)) dark = 1'b1;
`endif
    if (dark) return 7'h00;
    return hex_tbl[left ? r.data[7:4] : r.data[3:0]];
  endfunction

  // Compare all outputs, drive the next inputs, advance one clock.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] b,
                      input logic bl, output bit acc);
    rec_t r;
    chk("seg", {25'd0, seg}, {25'd0, exp_seg(e)});
    chk("digit_sel", {31'd0, digit_sel}, {31'd0, ((e / D) % 2 == 1)});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, (e % (2*D) == 2*D-1)});
    chk("upd_ready", {31'd0, u_if.upd_ready}, {31'd0, ready_at(e)});
    acc = v && ready_at(e);
    if (acc) begin
      r.data = d; r.blank = b; r.blink = bl;
      r.app  = ((e + 1) / (2*D) + 1) * (2*D);
      recs.push_back(r);
    end
    u_if.upd_valid = v;
    u_if.upd_data  = d;
    u_if.upd_blank = b;
    u_if.upd_blink = bl;
    @(posedge ACLK);
    #1;
    e++;
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 8'h00, 2'b00, 1'b0, a);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    u_if.upd_valid = 1'b0;
    #1;
    chk("rst_seg", {25'd0, seg}, 32'd0);
    chk("rst_digit_sel", {31'd0, digit_sel}, 32'd0);
    chk("rst_ready", {31'd0, u_if.upd_ready}, 32'd1);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    recs.delete();
    e = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] b, input logic bl,
                      output int stalls);
    bit a;
    stalls = 0;
    a = 1'b0;
    for (int k = 0; k < 100 && !a; k++) begin
      step(1'b1, d, b, bl, a);
      if (!a) stalls++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int   st, app, eh;
    bit   a;

    u_if.upd_valid = 1'b0;
    u_if.upd_data  = 8'h00;
    u_if.upd_blank = 2'b00;
    u_if.upd_blink = 1'b0;

    vt[0] = '{8'h3A, 2'b00, 7'h4F, 7'h77};
    vt[1] = '{8'h88, 2'b10, 7'h00, 7'h7F};
    vt[2] = '{8'h12, 2'b00, 7'h06, 7'h5B};
    vt[3] = '{8'hBC, 2'b01, 7'h7C, 7'h00};
    vt[4] = '{8'hDE, 2'b00, 7'h5E, 7'h79};
    vt[5] = '{8'hF0, 2'b00, 7'h71, 7'h3F};
    vt[6] = '{8'h69, 2'b00, 7'h7D, 7'h6F};

    do_reset();
    for (int k = 0; k < 3 * 2 * D; k++) idle();

    // Table vectors: commit each value, then check both slots.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 100 && !ready_at(e); k++) idle();
      send(vt[i].data, vt[i].blank, 1'b0, st);
      app = recs[recs.size()-1].app;
      for (int k = 0; k < 100 && e < app; k++) idle();
      chk($sformatf("vec%0d_right", i), {25'd0, seg}, {25'd0, vt[i].exp_r});
      chk($sformatf("vec%0d_sel_r", i), {31'd0, digit_sel}, 32'd0);
      for (int k = 0; k < D; k++) idle();
      chk($sformatf("vec%0d_left", i), {25'd0, seg}, {25'd0, vt[i].exp_l});
      chk($sformatf("vec%0d_sel_l", i), {31'd0, digit_sel}, 32'd1);
    end

    // Handshake coinciding with frame_tick lands one frame later.
    for (int k = 0; k < 100 && (e % (2*D) != 2*D-1); k++) idle();
    eh = e;
    step(1'b1, 8'h55, 2'b00, 1'b0, a);
    chk("sc_accept", {31'd0, a}, 32'd1);
    chk("sc_old_right", {25'd0, seg}, 32'h6F);
    for (int k = 0; k < 100 && e < eh + 2*D; k++) idle();
    chk("sc_still_old", {25'd0, seg}, 32'h7D);
    idle();
    chk("sc_new_right", {25'd0, seg}, 32'h6D);

    // Back-to-back updates: the second must stall until ready returns.
    for (int k = 0; k < 100 && !ready_at(e); k++) idle();
    send(8'h12, 2'b00, 1'b0, st);
    send(8'h34, 2'b00, 1'b0, st);
    chk("b2b_stalled", {31'd0, (st > 0)}, 32'd1);
    for (int k = 0; k < 6 * D; k++) idle();

    // Blink request: dark/lit alternation only with the blink build.
    for (int k = 0; k < 100 && !ready_at(e); k++) idle();
    send(8'h88, 2'b00, 1'b1, st);
    for (int k = 0; k < 10 * D; k++) idle();

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        @(negedge ACLK);
        do_reset();
      end
      step(($urandom % 3) == 0, 8'($urandom), 2'($urandom), 1'($urandom), a);
    end
    for (int k = 0; k < 4 * D; k++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
